uart_tx: RTL and testbench

Byte-serial UART transmitter driving the CPU's `io_tx` pin, the outbound counterpart of the `io_rx` program-load receiver. A store path (memory-mapped output register, console, or debug dump) pushes bytes through a valid/ready port into a small FIFO. The block serializes them as 8N1 frames (1 start, 8 data LSB-first, 1 stop, no parity) at a fixed baud divisor. It sits at the top level beside `cpu`, in the same `clk` domain.

---
 rtl/uart_tx.sv | 159 +++++++++++++++
 tb/tb_uart_tx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: byte FIFO feeding an 8N1 serializer (1 start, 8 data LSB-first, 1 stop).
// The line output is registered and idles high; queued bytes go out back-to-back.
module uart_tx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic                         tx_valid_i,
   input  logic [7:0]                   tx_data_i,
   output logic                         tx_ready_o,
   output logic                         tx_busy_o,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_count_o,
   output logic                         io_tx_o
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [PW:0]   FULL_CNT  = (PW+1)'(FIFO_DEPTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW:0]   count_q, count_d;
   logic [1:0]    state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;

   logic full, empty, push, pop, baud_last;
   logic [7:0] head;

   assign full      = (count_q == FULL_CNT);
   assign empty     = (count_q == '0);
   // Readiness comes from the registered count only, so a pop never frees a slot
   // for a write on the same edge.
   assign push      = tx_valid_i && !full;
   assign baud_last = (baud_q == BAUD_LAST);
   assign head      = mem_q[rd_ptr_q];

   assign tx_ready_o   = !full;
   assign tx_busy_o    = (state_q != S_IDLE) || !empty;
   assign fifo_count_o = count_q;
   assign io_tx_o      = tx_q;

   // Serializer next-state: one bit every CLKS_PER_BIT cycles, pop on frame start.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      pop     = 1'b0;
      case (state_q)
         S_IDLE: begin
            tx_d = 1'b1;
            if (!empty) begin
               pop     = 1'b1;
               shift_d = head;
               baud_d  = '0;
               bit_d   = '0;
               tx_d    = 1'b0;
               state_d = S_START;
            end
         end
         S_START: begin
            if (baud_last) begin
               baud_d  = '0;
               tx_d    = shift_q[0];
               state_d = S_DATA;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         S_DATA: begin
            if (baud_last) begin
               baud_d  = '0;
               shift_d = shift_q >> 1;
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = S_STOP;
               end else begin
                  // shift_q[1] becomes the new LSB after this shift
                  tx_d = shift_q[1];
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         S_STOP: begin
            if (baud_last) begin
               baud_d = '0;
               if (!empty) begin
                  // chain the next frame with no idle gap
                  pop     = 1'b1;
                  shift_d = head;
                  bit_d   = '0;
                  tx_d    = 1'b0;
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
         end
      endcase
   end

   // FIFO pointer and occupancy next-state; pointers wrap naturally.
   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
   end

   // Storage array; stale contents are harmless because pointers reset.
   always_ff @(posedge clk_i) begin
      if (push && !reset_i) mem_q[wr_ptr_q] <= tx_data_i;
   end

   // State registers with synchronous reset; reset drops in-flight and queued bytes.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= S_IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed + randomized checks of uart_tx against an 8N1 frame model
// and a behavioural line sampler.
module tb_uart_tx;

   localparam int CPB4 = 4;
   localparam int CPB8 = 8;

   logic       clk;
   logic       rst4, v4, rdy4, busy4, tx4;
   logic [7:0] d4;
   logic [2:0] cnt4;
   logic       rst8, v8, rdy8, busy8, tx8;
   logic [7:0] d8;
   logic [2:0] cnt8;

   int n_assert = 0;
   int n_fail   = 0;

   logic [7:0] rxq4[$];
   logic [7:0] rxq8[$];
   int         ferr4 = 0;
   int         ferr8 = 0;

   uart_tx #(.CLKS_PER_BIT(CPB4), .FIFO_DEPTH(4)) dut4 (
      .clk_i(clk), .reset_i(rst4), .tx_valid_i(v4), .tx_data_i(d4),
      .tx_ready_o(rdy4), .tx_busy_o(busy4), .fifo_count_o(cnt4), .io_tx_o(tx4));

   uart_tx #(.CLKS_PER_BIT(CPB8), .FIFO_DEPTH(4)) dut8 (
      .clk_i(clk), .reset_i(rst8), .tx_valid_i(v8), .tx_data_i(d8),
      .tx_ready_o(rdy8), .tx_busy_o(busy8), .fifo_count_o(cnt8), .io_tx_o(tx8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #700000;
      $display("FAIL watchdog: observed timeout required completion");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Line level of an 8N1 frame at bit position 0..9 (0 = start, 9 = stop).
   function automatic logic frame_bit(input logic [7:0] d, input int pos);
      if (pos == 0) return 1'b0;
      if (pos == 9) return 1'b1;
      return d[pos-1];
   endfunction

   // Mid-bit samplers: detect a low level, then sample each bit at its centre.
   initial begin : rx4_mon
      logic [7:0] b;
      logic       ok;
      forever begin
         @(negedge clk);
         if (tx4 === 1'b0) begin
            repeat (CPB4/2) @(negedge clk);
            ok = (tx4 === 1'b0);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB4) @(negedge clk);
               b[i] = tx4;
            end
            repeat (CPB4) @(negedge clk);
            if (tx4 !== 1'b1) ok = 1'b0;
            rxq4.push_back(b);
            if (!ok) ferr4++;
         end
      end
   end

   initial begin : rx8_mon
      logic [7:0] b;
      logic       ok;
      forever begin
         @(negedge clk);
         if (tx8 === 1'b0) begin
            repeat (CPB8/2) @(negedge clk);
            ok = (tx8 === 1'b0);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB8) @(negedge clk);
               b[i] = tx8;
            end
            repeat (CPB8) @(negedge clk);
            if (tx8 !== 1'b1) ok = 1'b0;
            rxq8.push_back(b);
            if (!ok) ferr8++;
         end
      end
   end

   initial begin : main
      logic       acc, lowseen, busyseen;
      int         guard;
      logic [7:0] exp_q[$];
      logic [7:0] got;

      // reset, with tx_valid held high throughout
      rst4 = 1'b1; rst8 = 1'b1; v4 = 1'b1; d4 = 8'h33; v8 = 1'b0; d8 = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_io_tx", 32'(tx4), 1);
      chk("rst_ready", 32'(rdy4), 1);
      chk("rst_busy", 32'(busy4), 0);
      chk("rst_count", 32'(cnt4), 0);
      chk("rst_io_tx8", 32'(tx8), 1);
      rst4 = 1'b0; rst8 = 1'b0; v4 = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_valid_ignored", 32'(cnt4), 0);
      chk("rst_idle_line", 32'(tx4), 1);

      // single byte 0xA5: exact cycle-level waveform
      d4 = 8'hA5; v4 = 1'b1;
      @(negedge clk);
      v4 = 1'b0; d4 = 8'h5A;
      chk("a5_count_after_accept", 32'(cnt4), 1);
      chk("a5_line_before_start", 32'(tx4), 1);
      chk("a5_busy_after_accept", 32'(busy4), 1);
      for (int j = 1; j <= 44; j++) begin
         @(negedge clk);
         chk("a5_line", 32'(tx4), 32'((j <= 40) ? frame_bit(8'hA5, (j-1)/CPB4) : 1'b1));
         chk("a5_busy", 32'(busy4), 32'(j <= 40));
         if (j == 1) chk("a5_count_after_pop", 32'(cnt4), 0);
      end
      chk("a5_rx_count", 32'(rxq4.size()), 1);
      if (rxq4.size() > 0) begin
         got = rxq4.pop_front();
         chk("a5_rx_byte", 32'(got), 32'h A5);
      end

      // burst of five, then a write against a full FIFO coinciding with a pop
      for (int i = 1; i <= 5; i++) begin
         d4 = 8'(i); v4 = 1'b1;
         chk("burst_ready", 32'(rdy4), 1);
         @(negedge clk);
      end
      v4 = 1'b0;
      chk("burst_count_full", 32'(cnt4), 4);
      chk("burst_ready_full", 32'(rdy4), 0);
      for (int j = 5; j <= 244; j++) begin
         @(negedge clk);
         chk("burst_line", 32'(tx4),
             32'((j <= 240) ? frame_bit(8'((j-1)/40 + 1), ((j-1)%40)/CPB4) : 1'b1));
         if (j == 40) begin
            chk("full_count_before_pop", 32'(cnt4), 4);
            chk("full_ready_before_pop", 32'(rdy4), 0);
            d4 = 8'h06; v4 = 1'b1;
         end
         if (j == 41) begin
            chk("full_refused_count", 32'(cnt4), 3);
            chk("full_ready_after_pop", 32'(rdy4), 1);
         end
         if (j == 42) begin
            chk("full_accept_count", 32'(cnt4), 4);
            chk("full_ready_again", 32'(rdy4), 0);
            v4 = 1'b0;
         end
         if (j == 240) chk("burst_busy_last", 32'(busy4), 1);
         if (j == 241) chk("burst_busy_fall", 32'(busy4), 0);
      end
      chk("burst_rx_count", 32'(rxq4.size()), 6);
      for (int i = 1; i <= 6; i++) begin
         if (rxq4.size() > 0) begin
            got = rxq4.pop_front();
            chk("burst_rx_byte", 32'(got), 32'(i));
         end
      end
      chk("burst_framing", 32'(ferr4), 0);

      // reset mid-frame with two bytes queued
      d4 = 8'hFF; v4 = 1'b1;
      @(negedge clk);
      d4 = 8'h11;
      @(negedge clk);
      d4 = 8'h22;
      @(negedge clk);
      v4 = 1'b0;
      chk("midrst_queued", 32'(cnt4), 2);
      repeat (13) @(negedge clk);
      rst4 = 1'b1;
      @(negedge clk);
      rst4 = 1'b0;
      chk("midrst_line", 32'(tx4), 1);
      chk("midrst_count", 32'(cnt4), 0);
      chk("midrst_busy", 32'(busy4), 0);
      chk("midrst_ready", 32'(rdy4), 1);
      lowseen = 1'b0; busyseen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (tx4 !== 1'b1) lowseen = 1'b1;
         if (busy4 !== 1'b0) busyseen = 1'b1;
      end
      chk("midrst_no_frame", 32'(lowseen), 0);
      chk("midrst_stays_idle", 32'(busyseen), 0);
      rxq4.delete();

      // loopback: 0x00..0xFF with random gaps and noise on tx_data while idle
      for (int b = 0; b < 256; b++) begin
         repeat ($urandom_range(0, 3)) begin
            d8 = 8'($urandom);
            @(negedge clk);
         end
         d8 = 8'(b); v8 = 1'b1;
         guard = 0;
         do begin
            acc = rdy8;
            @(negedge clk);
            guard++;
         end while (!acc && guard < 2000);
         chk("lb_accept", 32'(acc), 1);
         if (acc) exp_q.push_back(8'(b));
         v8 = 1'b0;
      end
      guard = 0;
      while ((rxq8.size() < 256 || busy8) && guard < 30000) begin
         @(negedge clk);
         guard++;
      end
      chk("lb_rx_count", 32'(rxq8.size()), 256);
      chk("lb_busy_done", 32'(busy8), 0);
      chk("lb_framing", 32'(ferr8), 0);
      for (int i = 0; i < 256; i++) begin
         if (rxq8.size() > 0 && exp_q.size() > 0) begin
            got = rxq8.pop_front();
            chk("lb_rx_byte", 32'(got), 32'(exp_q.pop_front()));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
